// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: drives a word bus with byte enables and an
// ack handshake, formats load data for write-back, and reports misalign/timeout.
//
// state  | meaning
// IDLE   | waiting for req; misaligned requests go straight to RESP
// ACCESS | bus_req held, waiting for bus_ack or wait-counter expiry
// RESP   | one-cycle done/misalign/buserr pulse, then back to IDLE
module mem_access_unit #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req,
  input  logic        wmem,
  input  logic [1:0]  size,
  input  logic        lunsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] di,
  output logic        stall,
  output logic        done,
  output logic        misalign,
  output logic        buserr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_req_q, bus_req_d;
  logic          we_q, we_d;
  logic [31:0]   baddr_q, baddr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   bwdata_q, bwdata_d;
  logic [1:0]    lo_q, lo_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [31:0]   di_q, di_d;
  logic          done_q, done_d;
  logic          misalign_q, misalign_d;
  logic          buserr_q, buserr_d;

  logic          misaligned;
  logic [3:0]    be_new;
  logic [31:0]   wdata_rep;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_fmt;

  assign misaligned = ((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00));

  // Store lane placement; loads always fetch the whole word.
  always_comb begin
    be_new    = 4'b1111;
    wdata_rep = wdata;
    case (size)
      2'b00: begin
        wdata_rep = {4{wdata[7:0]}};
        if (wmem) be_new = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        wdata_rep = {2{wdata[15:0]}};
        if (wmem) be_new = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_rep = wdata;
        be_new    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_byte = bus_rdata[7:0];
    case (lo_q)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'b00:   ld_fmt = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_fmt = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_fmt = bus_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bus_req_d  = bus_req_q;
    we_d       = we_q;
    baddr_d    = baddr_q;
    be_d       = be_q;
    bwdata_d   = bwdata_q;
    lo_d       = lo_q;
    size_d     = size_q;
    uns_d      = uns_q;
    di_d       = di_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    buserr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (misaligned) begin
            state_d    = RESP;
            misalign_d = 1'b1;
          end else begin
            state_d   = ACCESS;
            cnt_d     = '0;
            bus_req_d = 1'b1;
            we_d      = wmem;
            baddr_d   = {addr[31:2], 2'b00};
            be_d      = be_new;
            bwdata_d  = wdata_rep;
            lo_d      = addr[1:0];
            size_d    = size;
            uns_d     = lunsigned;
          end
        end
      end
      ACCESS: begin
        // An ack in the last allowed cycle wins over the timeout.
        if (bus_ack) begin
          state_d   = RESP;
          bus_req_d = 1'b0;
          done_d    = 1'b1;
          if (!we_q) di_d = ld_fmt;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RESP;
          bus_req_d = 1'b0;
          buserr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bus_req_q  <= 1'b0;
      we_q       <= 1'b0;
      baddr_q    <= '0;
      be_q       <= '0;
      bwdata_q   <= '0;
      lo_q       <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      di_q       <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bus_req_q  <= bus_req_d;
      we_q       <= we_d;
      baddr_q    <= baddr_d;
      be_q       <= be_d;
      bwdata_q   <= bwdata_d;
      lo_q       <= lo_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      di_q       <= di_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
      buserr_q   <= buserr_d;
    end
  end

  // Gated by clrn so stall is also low while reset is held with req asserted.
  assign stall     = clrn & ((state_q == ACCESS) | ((state_q == IDLE) & req));
  assign di        = di_q;
  assign done      = done_q;
  assign misalign  = misalign_q;
  assign buserr    = buserr_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = we_q;
  assign bus_addr  = baddr_q;
  assign bus_be    = be_q;
  assign bus_wdata = bwdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit with MAX_WAIT=4, plus a
// reset-during-access sequence.
module tb_mem_access_unit;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        req = 1'b0;
  logic        wmem = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        lunsigned = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [31:0] di, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        stall, done, misalign, buserr, bus_req, bus_we;

  mem_access_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .clrn(clrn), .req(req), .wmem(wmem), .size(size),
    .lunsigned(lunsigned), .addr(addr), .wdata(wdata), .di(di),
    .stall(stall), .done(done), .misalign(misalign), .buserr(buserr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model_di = '0;

  // kind: 0 done, 1 misalign, 2 buserr; cyc: cycle of the pulse after acceptance
  typedef struct {
    logic        wm;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          nw;
    logic [3:0]  be;
    logic [31:0] bwd;
    int          kind;
    int          cyc;
    logic [31:0] ldv;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit seen;
    logic [2:0] expf;
    expf = (v.kind == 0) ? 3'b100 : (v.kind == 1) ? 3'b010 : 3'b001;
    @(negedge clk);
    req = 1'b1; wmem = v.wm; size = v.sz; lunsigned = v.uns;
    addr = v.a; wdata = v.wd; bus_rdata = v.rd; bus_ack = 1'b0;
    #1;
    check($sformatf("v%0d stall c0", idx), 32'(stall), 32'd1);
    seen = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      bus_ack = (k == 1 + v.nw) || (k == v.cyc);
      #1;
      check($sformatf("v%0d stall c%0d", idx, k), 32'(stall), 32'(k < v.cyc));
      check($sformatf("v%0d bus_req c%0d", idx, k), 32'(bus_req),
            32'((v.kind != 1) && (k < v.cyc)));
      if ((v.kind != 1) && (k < v.cyc)) begin
        check($sformatf("v%0d bus_addr c%0d", idx, k), bus_addr, {v.a[31:2], 2'b00});
        check($sformatf("v%0d bus_be c%0d", idx, k), 32'(bus_be), 32'(v.be));
        check($sformatf("v%0d bus_we c%0d", idx, k), 32'(bus_we), 32'(v.wm));
        if (v.wm) check($sformatf("v%0d bus_wdata c%0d", idx, k), bus_wdata, v.bwd);
      end
      if (done || misalign || buserr) begin
        seen = 1'b1;
        check($sformatf("v%0d pulses", idx), 32'({done, misalign, buserr}), 32'(expf));
        check($sformatf("v%0d pulse cycle", idx), 32'(k), 32'(v.cyc));
        if ((v.kind == 0) && !v.wm) model_di = v.ldv;
        check($sformatf("v%0d di", idx), di, model_di);
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL v%0d no completion: got none, want pulse in cycle %0d", idx, v.cyc);
    end
    @(negedge clk);
    req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hA5A5_5A5A;
    #1;
    check($sformatf("v%0d idle pulses", idx), 32'({done, misalign, buserr}), 32'd0);
    check($sformatf("v%0d idle stall", idx), 32'(stall), 32'd0);
    check($sformatf("v%0d idle di", idx), di, model_di);
    bus_ack = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0,         32'h80FF_1234, 0,   4'b1111, 32'h0,         0, 2, 32'hFFFF_FF80};
    tbl[1]  = '{1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0,         32'h80FF_1234, 0,   4'b1111, 32'h0,         0, 2, 32'h0000_0080};
    tbl[2]  = '{1'b1, 2'd1, 1'b0, 32'h0000_2006, 32'h0000_BEEF, 32'hDEAD_DEAD, 0,   4'b1100, 32'hBEEF_BEEF, 0, 2, 32'h0};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0,         32'h0,         255, 4'b1111, 32'h0,         1, 1, 32'h0};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0,         32'h1111_2222, 255, 4'b1111, 32'h0,         2, 5, 32'h0};
    tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0,         32'h1234_5678, 3,   4'b1111, 32'h0,         0, 5, 32'h1234_5678};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h0000_3002, 32'h0,         32'h8001_7FFF, 3,   4'b1111, 32'h0,         0, 5, 32'hFFFF_8001};
    tbl[7]  = '{1'b1, 2'd0, 1'b0, 32'h0000_5001, 32'h0000_00A5, 32'h0,         1,   4'b0010, 32'hA5A5_A5A5, 0, 3, 32'h0};
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 32'h0000_3000, 32'h0,         32'h8001_7FFF, 0,   4'b1111, 32'h0,         0, 2, 32'h0000_7FFF};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 32'h0000_6001, 32'h0,         32'h0000_7F00, 0,   4'b1111, 32'h0,         0, 2, 32'h0000_007F};
    tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h0000_7000, 32'hDEAD_BEEF, 32'h0,         2,   4'b1111, 32'hDEAD_BEEF, 0, 4, 32'h0};
    tbl[11] = '{1'b0, 2'd1, 1'b0, 32'h0000_3001, 32'h0,         32'h0,         255, 4'b1111, 32'h0,         1, 1, 32'h0};
    tbl[12] = '{1'b0, 2'd3, 1'b0, 32'h0000_8000, 32'h0,         32'hCAFE_F00D, 0,   4'b1111, 32'h0,         0, 2, 32'hCAFE_F00D};
    tbl[13] = '{1'b1, 2'd1, 1'b0, 32'h0000_2005, 32'h0000_1234, 32'h0,         255, 4'b1111, 32'h0,         1, 1, 32'h0};
    tbl[14] = '{1'b1, 2'd0, 1'b0, 32'h0000_5003, 32'h1234_5677, 32'h0,         0,   4'b1000, 32'h7777_7777, 0, 2, 32'h0};
    tbl[15] = '{1'b0, 2'd0, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_00FE, 0,   4'b1111, 32'h0,         0, 2, 32'hFFFF_FFFE};
    tbl[16] = '{1'b0, 2'd1, 1'b1, 32'h0000_3002, 32'h0,         32'h8001_7FFF, 0,   4'b1111, 32'h0,         0, 2, 32'h0000_8001};

    // Reset with req high: every output must read zero.
    req = 1'b1;
    #12;
    check("rst stall", 32'(stall), 32'd0);
    check("rst bus_req", 32'(bus_req), 32'd0);
    check("rst pulses", 32'({done, misalign, buserr}), 32'd0);
    check("rst di", di, 32'd0);
    check("rst bus_addr", bus_addr, 32'd0);
    check("rst bus_be", 32'(bus_be), 32'd0);
    check("rst bus_wdata", bus_wdata, 32'd0);
    check("rst bus_we", 32'(bus_we), 32'd0);
    @(negedge clk);
    req = 1'b0;
    clrn = 1'b1;

    for (int i = 0; i < 17; i++) run_vec(tbl[i], i);

    // Reset asserted mid-access: outputs clear at once, no completion later.
    @(negedge clk);
    req = 1'b1; wmem = 1'b0; size = 2'd2; lunsigned = 1'b0;
    addr = 32'h0000_9000; bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    #1;
    check("mid bus_req before rst", 32'(bus_req), 32'd1);
    @(negedge clk);
    clrn = 1'b0;
    #1;
    check("mid rst bus_req", 32'(bus_req), 32'd0);
    check("mid rst stall", 32'(stall), 32'd0);
    check("mid rst di", di, 32'd0);
    model_di = '0;
    @(negedge clk);
    req = 1'b0;
    clrn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus_ack = (k == 1);
      #1;
      check($sformatf("post rst pulses c%0d", k), 32'({done, misalign, buserr}), 32'd0);
      check($sformatf("post rst bus_req c%0d", k), 32'(bus_req), 32'd0);
    end
    bus_ack = 1'b0;
    run_vec(tbl[0], 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit for the pipelined MIPS core. It accepts load/store requests from the EX/MEM register and drives a word-wide data bus with byte enables, waiting on an acknowledge handshake. It returns aligned, sign- or zero-extended load data on `di`, which feeds the write-back data-select mux. It stalls the pipeline while an access is outstanding and flags misaligned addresses and bus timeouts.

## Interface
- `MAX_WAIT`, 16: bus cycles allowed for `bus_ack` before a timeout error. Minimum 1.
- `clk` in 1: clock. All state updates on the rising edge.
- `clrn` in 1: reset, asynchronous, active-low.
- `req` in 1: access request. Held with all operands until `done`, `misalign` or `buserr` pulses.
- `wmem` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `lunsigned` in 1: zero-extend loads (lbu/lhu) when 1, sign-extend when 0.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-justified.
- `di` out 32: formatted load data to the write-back mux.
- `stall` out 1: freeze upstream pipeline registers.
- `done` out 1: one-cycle completion pulse.
- `misalign` out 1: one-cycle misaligned-address exception pulse.
- `buserr` out 1: one-cycle bus-timeout exception pulse.
- `bus_req` out 1: bus request. Held until ack or timeout.
- `bus_we` out 1: bus write.
- `bus_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `bus_be` out 4: byte enables. Bit k covers `bus_wdata[8k+7:8k]`.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_ack` in 1: access complete. Read data is valid in the same cycle.
- `bus_rdata` in 32: read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - On `req` with a misaligned address, go to RESP with `misalign` set. No bus cycle is issued.
  - On `req` with an aligned address, latch the operation, load the wait counter with 0 and go to ACCESS.
  - Misaligned means: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
- **ACCESS**
  - `bus_req`=1. `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` come from registers and stay stable for the whole state.
  - On `bus_ack`, go to RESP with `done` set. For loads, register the formatted `di` at the same time.
  - Without ack, if counter = `MAX_WAIT`-1, go to RESP with `buserr` set. Otherwise increment the counter.
- **RESP**
  - Exactly one of `done`, `misalign` or `buserr` is high. `stall`=0.
  - `req` is ignored in this state.
  - Always go to IDLE next.
- **Byte lanes (little-endian)**
  - Byte: `be`=1<<`addr[1:0]`, `wdata[7:0]` replicated ×4.
  - Half: `be`=`addr[1]` ? 1100 : 0011, `wdata[15:0]` replicated ×2.
  - Word: `be`=1111.
  - Loads drive `be`=1111.
- **Load formatting**
  - Select the byte or half addressed by the low address bits.
  - Extend to 32 bits per `lunsigned`.
- `di` holds its value until the next completed load. Stores, misaligns and timeouts leave it unchanged.
- `stall` = (state==ACCESS) | (state==IDLE & `req`). It is combinational, so a stall is visible in the same cycle as the request.

## Timing
- Reset (`clrn`=0, asynchronous): state IDLE, counter 0, and every output is 0, including `di`, `bus_*`, `done`, `misalign`, `buserr` and `stall`.
- Reset during ACCESS: `bus_req` drops immediately and no completion pulse is produced.
- Aligned access, request accepted at edge 0:
  - `bus_req` is high from cycle 1.
  - With ack in cycle 1+n (n wait states), `done` and the new `di` appear in cycle 2+n, and `bus_req` is low in that cycle.
  - Minimum latency is 2 cycles from acceptance.
- Misaligned access: `misalign` is high in cycle 1. `bus_req` never rises.
- Timeout: `bus_req` is high for exactly `MAX_WAIT` cycles, then `buserr` is high for one cycle.
- An ack that arrives in the final allowed cycle takes priority over the timeout.
- Ack outside ACCESS is ignored.
- Back-to-back requests: the earliest next acceptance is the edge after RESP, so there is one idle cycle between accesses.

## Test plan
- Byte loads at `addr`=0x1003 with `bus_rdata`=0x80FF1234, 0 wait states:
  - `bus_addr`=0x1000, `be`=1111.
  - lb gives `di`=0xFFFFFF80.
  - lbu gives `di`=0x00000080.
  - `done` is in cycle 2 after acceptance.
- sh at `addr`=0x2006 with `wdata`=0x0000BEEF → `bus_addr`=0x2004, `be`=1100, `bus_wdata`=0xBEEFBEEF, `bus_we`=1. After the ack, `done` pulses and `di` is unchanged.
- lw at `addr`=0x0102 → `misalign` high for one cycle in cycle 1. `bus_req` stays 0 throughout. `stall` is 1 in cycle 0 and 0 in cycle 1.
- `MAX_WAIT`=4 with `bus_ack` held 0 → `bus_req` high for cycles 1–4, `buserr` in cycle 5, `done` never asserts. Rerun with ack in cycle 4 → `done` in cycle 5 and no `buserr`.
- lh at 0x3002 with `bus_rdata`=0x8001_7FFF and 3 wait states → `stall` high for cycles 0–4, `di`=0xFFFF8001 with `done` in cycle 5.
- `clrn` pulsed low during ACCESS → `bus_req`, `stall` and `di` go to 0 immediately. After release, no `done` appears and a new request completes normally.
